// File: rtl/axis_pcim_burst_writer.sv
// axis_pcim_burst_writer
//   Result-return path: drains the wide CNN output stream and writes it to a ring of
//   fixed-size slots in host memory as AXI4 write bursts on the PCIM master port.
//   One burst is in flight at a time: IDLE -> ADDR -> DATA -> RESP -> IDLE.
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cfg_enable                    start new bursts while high; a running burst always completes
//   cfg_base_addr                 ring base, low 12 bits ignored
//   cfg_ring_bursts               ring size in bursts (0 behaves as 1)
//   s_axis_*                      result stream in (tdata/tvalid/tready)
//   m_axi_aw*, m_axi_w*, m_axi_b* AXI4 write channels (no read channels)
//   stat_bursts                   completed bursts (B received), wraps
//   stat_err                      sticky: any non-OKAY BRESP since reset
//   stat_busy                     high whenever the FSM is not idle
module axis_pcim_burst_writer #(
  parameter int unsigned    DATA_W    = 512,
  parameter int unsigned    ADDR_W    = 64,
  parameter int unsigned    ID_W      = 16,
  parameter int unsigned    BURST_LEN = 64,
  parameter logic [ID_W-1:0] AWID_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [15:0]           cfg_ring_bursts,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ID_W-1:0]       m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_W-1:0]       m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [31:0]           stat_bursts,
  output logic                  stat_err,
  output logic                  stat_busy
);

  localparam int unsigned StrbW     = DATA_W / 8;
  localparam int unsigned BeatW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned SlotBytes = BURST_LEN * StrbW;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e              state_q, state_d;
  logic [15:0]         idx_q, idx_d;
  logic [15:0]         ring_q, ring_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [31:0]         bursts_q, bursts_d;
  logic                err_q, err_d;
  logic [15:0]         start_idx;
  logic [ADDR_W-1:0]   base_aligned;

  // Bid and the forced-zero base bits carry no information for this block.
  logic unused_in;
  assign unused_in = ^{m_axi_bid, cfg_base_addr[11:0]};

  assign base_aligned = {cfg_base_addr[ADDR_W-1:12], 12'h000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      ring_q   <= 16'd1;
      awaddr_q <= '0;
      beat_q   <= '0;
      bursts_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ring_q   <= ring_d;
      awaddr_q <= awaddr_d;
      beat_q   <= beat_d;
      bursts_q <= bursts_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ring_d        = ring_q;
    awaddr_d      = awaddr_q;
    beat_d        = beat_q;
    bursts_d      = bursts_q;
    err_d         = err_q;
    start_idx     = idx_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    s_axis_tready = 1'b0;
    m_axi_bready  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_enable) begin
          ring_d    = (cfg_ring_bursts == 16'd0) ? 16'd1 : cfg_ring_bursts;
          // A ring shrunk below the current slot restarts at the base.
          start_idx = (idx_q >= ring_d) ? 16'd0 : idx_q;
          idx_d     = start_idx;
          awaddr_d  = base_aligned + ADDR_W'(start_idx) * ADDR_W'(SlotBytes);
          state_d   = StAddr;
        end
      end
      StAddr: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          state_d = StData;
        end
      end
      StData: begin
        // Zero-latency passthrough: stream handshake is the W handshake.
        m_axi_wvalid  = s_axis_tvalid;
        s_axis_tready = m_axi_wready;
        m_axi_wlast   = (beat_q == LastBeat);
        if (s_axis_tvalid && m_axi_wready) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StResp;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StResp: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          bursts_d = bursts_q + 32'd1;
          err_d    = err_q | (m_axi_bresp != 2'b00);
          idx_d    = (idx_q + 16'd1 == ring_q) ? 16'd0 : idx_q + 16'd1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign m_axi_awid   = AWID_VAL;
  assign m_axi_awaddr = awaddr_q;
  assign m_axi_awlen  = 8'(BURST_LEN - 1);
  assign m_axi_awsize = 3'($clog2(StrbW));
  assign m_axi_wdata  = s_axis_tdata;
  assign m_axi_wstrb  = '1;
  assign stat_bursts  = bursts_q;
  assign stat_err     = err_q;
  assign stat_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_axis_pcim_burst_writer.sv
module tb_axis_pcim_burst_writer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_enable;
  logic [63:0]   cfg_base_addr;
  logic [15:0]   cfg_ring_bursts;
  logic [511:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [15:0]   m_axi_awid;
  logic [63:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [511:0]  m_axi_wdata;
  logic [63:0]   m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [15:0]   m_axi_bid;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic [31:0]   stat_bursts;
  logic          stat_err;
  logic          stat_busy;

  always #5 clk = ~clk;

  axis_pcim_burst_writer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_enable      (cfg_enable),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_ring_bursts (cfg_ring_bursts),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .m_axi_awid      (m_axi_awid),
    .m_axi_awaddr    (m_axi_awaddr),
    .m_axi_awlen     (m_axi_awlen),
    .m_axi_awsize    (m_axi_awsize),
    .m_axi_awvalid   (m_axi_awvalid),
    .m_axi_awready   (m_axi_awready),
    .m_axi_wdata     (m_axi_wdata),
    .m_axi_wstrb     (m_axi_wstrb),
    .m_axi_wlast     (m_axi_wlast),
    .m_axi_wvalid    (m_axi_wvalid),
    .m_axi_wready    (m_axi_wready),
    .m_axi_bid       (m_axi_bid),
    .m_axi_bresp     (m_axi_bresp),
    .m_axi_bvalid    (m_axi_bvalid),
    .m_axi_bready    (m_axi_bready),
    .stat_bursts     (stat_bursts),
    .stat_err        (stat_err),
    .stat_busy       (stat_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboards: stream beats in offer order, AW addresses in burst order.
  logic [511:0] exp_w[$];
  logic [63:0]  exp_aw[$];

  bit  rand_mode = 1'b0;
  int  src_limit = 0;   // beats the source may offer in total
  int  src_acc = 0;     // beats accepted on the stream
  int  src_pushed = 0;
  int  held_idx = -1;
  int  aw_cnt = 0;
  int  wlast_cnt = 0;
  int  b_done = 0;
  int  b_held = -1;
  int  err_burst = -1;
  int  mon_beat = 0;
  int  exp_idx = 0;
  bit  aw_hold = 1'b0;
  logic [63:0] aw_hold_addr;

  function automatic logic [511:0] mk(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'hC0DE_0000;
    return {16{w}};
  endfunction

  function automatic logic [63:0] slot_addr(input int idx);
    return (cfg_base_addr & ~64'hFFF) + 64'(idx) * 64'h1000;
  endfunction

  task automatic push_aw(input int n);
    int ring;
    ring = (cfg_ring_bursts == 16'd0) ? 1 : int'(cfg_ring_bursts);
    for (int k = 0; k < n; k++) begin
      exp_aw.push_back(slot_addr(exp_idx));
      exp_idx = (exp_idx + 1 == ring) ? 0 : exp_idx + 1;
    end
  endtask

  // Stream source: holds a beat until accepted, pushes each new beat once.
  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (src_acc >= src_limit) s_axis_tvalid = 1'b0;
      else if (!(s_axis_tvalid && src_acc == held_idx))
        s_axis_tvalid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (s_axis_tvalid) begin
        held_idx     = src_acc;
        s_axis_tdata = mk(src_acc);
        if (src_acc == src_pushed) begin
          exp_w.push_back(mk(src_acc));
          src_pushed = src_acc + 1;
        end
      end
    end
  end

  initial begin
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axi_awready = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      m_axi_wready  = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // B responder: one response per accepted wlast, held until taken.
  initial begin
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    m_axi_bid    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!(m_axi_bvalid && b_done == b_held)) begin
        m_axi_bvalid = (wlast_cnt > b_done) && (!rand_mode || $urandom_range(0, 2) == 0);
        if (m_axi_bvalid) begin
          b_held      = b_done;
          m_axi_bresp = (b_done == err_burst) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Monitor: samples at negedge the handshakes that complete on the next posedge.
  always @(negedge clk) begin
    logic [511:0] ew;
    logic [63:0]  ea;
    bit s_hs, w_hs, exp_last;
    if (!rst_n) begin
      mon_beat = 0;
      aw_hold  = 1'b0;
    end else begin
      if (m_axi_awvalid) begin
        if (aw_hold) begin
          n_checks++;
          if (m_axi_awaddr !== aw_hold_addr) begin
            n_errors++;
            $display("FAIL aw_stable: awaddr=%h required %h", m_axi_awaddr, aw_hold_addr);
          end
        end
        if (m_axi_awready) begin
          aw_cnt++;
          aw_hold = 1'b0;
          n_checks++;
          if (exp_aw.size() == 0) begin
            n_errors++;
            $display("FAIL aw_unexpected: awaddr=%h required no burst", m_axi_awaddr);
          end else begin
            ea = exp_aw.pop_front();
            if (m_axi_awaddr !== ea || m_axi_awlen !== 8'd63 || m_axi_awsize !== 3'd6 ||
                m_axi_awid !== 16'd0) begin
              n_errors++;
              $display("FAIL aw_fields: addr=%h len=%0d size=%0d id=%0d required addr=%h len=63 size=6 id=0",
                       m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awid, ea);
            end
          end
        end else begin
          aw_hold      = 1'b1;
          aw_hold_addr = m_axi_awaddr;
        end
      end else if (aw_hold) begin
        aw_hold = 1'b0;
        n_checks++;
        n_errors++;
        $display("FAIL aw_withdrawn: awvalid=0 required 1 until awready");
      end

      if (m_axi_wvalid) begin
        n_checks++;
        if (m_axi_awvalid !== 1'b0) begin
          n_errors++;
          $display("FAIL aw_w_overlap: awvalid=%b required 0 while wvalid", m_axi_awvalid);
        end
      end

      s_hs = s_axis_tvalid && s_axis_tready;
      w_hs = m_axi_wvalid && m_axi_wready;
      if (s_hs || w_hs) begin
        n_checks++;
        if (s_hs != w_hs) begin
          n_errors++;
          $display("FAIL stream_w_coupling: s_hs=%b w_hs=%b required equal", s_hs, w_hs);
        end
      end
      if (s_hs) src_acc++;
      if (w_hs) begin
        exp_last = (mon_beat == 63);
        n_checks++;
        if (exp_w.size() == 0) begin
          n_errors++;
          $display("FAIL w_unexpected: wdata=%h required no beat", m_axi_wdata[31:0]);
        end else begin
          ew = exp_w.pop_front();
          if (m_axi_wdata !== ew || m_axi_wlast !== exp_last) begin
            n_errors++;
            $display("FAIL w_beat%0d: data=%h last=%b required data=%h last=%b",
                     mon_beat, m_axi_wdata[31:0], m_axi_wlast, ew[31:0], exp_last);
          end
        end
        if (exp_last) wlast_cnt++;
        mon_beat = exp_last ? 0 : mon_beat + 1;
      end
      if (m_axi_bvalid && m_axi_bready) b_done++;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    cfg_enable = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n   = 1'b1;
    exp_idx = 0;
    exp_aw.delete();
    @(negedge clk);
  endtask

  // Runs n bursts: enable until the n-th AW handshake, then wait for all B responses.
  task automatic run_bursts(input int n);
    int aw_t, b_t;
    aw_t       = aw_cnt + n;
    b_t        = b_done + n;
    src_limit  = src_limit + 64 * n;
    cfg_enable = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (aw_cnt >= aw_t) break;
      @(negedge clk);
    end
    cfg_enable = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (b_done >= b_t && !stat_busy) break;
      @(negedge clk);
    end
    n_checks++;
    if (b_done < b_t || stat_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL burst_timeout: b_done=%0d busy=%b required %0d and 0", b_done, stat_busy, b_t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready, stat_busy,
         stat_err} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: aw/w/last/b/tready/busy/err=%b required 0000000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready,
                stat_busy, stat_err});
    end
    n_checks++;
    if (stat_bursts !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_bursts: stat_bursts=%0d required 0", stat_bursts);
    end
    n_checks++;
    if (m_axi_awlen !== 8'd63 || m_axi_awsize !== 3'd6 || m_axi_wstrb !== {64{1'b1}}) begin
      n_errors++;
      $display("FAIL reset_consts: awlen=%0d awsize=%0d wstrb=%h required 63 6 all-ones",
               m_axi_awlen, m_axi_awsize, m_axi_wstrb);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    cfg_base_addr   = 64'h1_0000_0000;
    cfg_ring_bursts = 16'd4;
    push_aw(1);
    run_bursts(1);
    n_checks++;
    if (stat_bursts !== 32'd1) begin
      n_errors++;
      $display("FAIL single_bursts: stat_bursts=%0d required 1", stat_bursts);
    end
    n_checks++;
    if (exp_w.size() != 0 || exp_aw.size() != 0) begin
      n_errors++;
      $display("FAIL single_drain: w_left=%0d aw_left=%0d required 0 0", exp_w.size(), exp_aw.size());
    end
  endtask

  task automatic test_ring_wrap();
    do_reset();
    cfg_base_addr   = 64'h1_0000_0000;
    cfg_ring_bursts = 16'd2;
    push_aw(3);
    run_bursts(3);
    n_checks++;
    if (stat_bursts !== 32'd3 || exp_aw.size() != 0) begin
      n_errors++;
      $display("FAIL wrap_bursts: stat_bursts=%0d aw_left=%0d required 3 0", stat_bursts, exp_aw.size());
    end
  endtask

  task automatic test_random_stalls();
    do_reset();
    rand_mode       = 1'b1;
    cfg_base_addr   = 64'h2_0000_5ABC;
    cfg_ring_bursts = 16'd3;
    push_aw(4);
    run_bursts(4);
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (stat_bursts !== 32'd4 || exp_w.size() != 0 || exp_aw.size() != 0) begin
      n_errors++;
      $display("FAIL random_drain: bursts=%0d w_left=%0d aw_left=%0d required 4 0 0",
               stat_bursts, exp_w.size(), exp_aw.size());
    end
  endtask

  task automatic test_bresp_error();
    do_reset();
    cfg_base_addr   = 64'h3_0000_0000;
    cfg_ring_bursts = 16'd4;
    err_burst       = b_done;
    push_aw(1);
    run_bursts(1);
    n_checks++;
    if (stat_err !== 1'b1 || stat_bursts !== 32'd1) begin
      n_errors++;
      $display("FAIL err_set: stat_err=%b bursts=%0d required 1 1", stat_err, stat_bursts);
    end
    push_aw(1);
    run_bursts(1);
    n_checks++;
    if (stat_err !== 1'b1 || stat_bursts !== 32'd2) begin
      n_errors++;
      $display("FAIL err_sticky: stat_err=%b bursts=%0d required 1 2", stat_err, stat_bursts);
    end
  endtask

  task automatic test_enable_drop();
    int b_t;
    b_t       = b_done + 1;
    src_limit = src_limit + 68;  // four extra beats must stay parked in the source
    push_aw(1);
    cfg_enable = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (mon_beat >= 10) break;
      @(negedge clk);
    end
    cfg_enable = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (b_done >= b_t && !stat_busy) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (stat_busy !== 1'b0 || s_axis_tready !== 1'b0 || m_axi_awvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_idle: busy=%b tready=%b awvalid=%b required 0 0 0",
               stat_busy, s_axis_tready, m_axi_awvalid);
    end
    n_checks++;
    if (stat_bursts !== 32'd3 || src_acc != src_limit - 4 || exp_aw.size() != 0) begin
      n_errors++;
      $display("FAIL drop_complete: bursts=%0d accepted=%0d aw_left=%0d required 3 %0d 0",
               stat_bursts, src_acc, exp_aw.size(), src_limit - 4);
    end
  endtask

  task automatic test_reset_mid_burst();
    cfg_base_addr   = 64'h4_0000_0000;
    cfg_ring_bursts = 16'd4;
    src_limit       = src_acc + 64;
    push_aw(1);
    cfg_enable = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (mon_beat >= 30) break;
      @(negedge clk);
    end
    n_checks++;
    if (mon_beat < 30) begin
      n_errors++;
      $display("FAIL midrst_reach: beat=%0d required 30", mon_beat);
    end
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    cfg_enable = 1'b0;
    #1;
    n_checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready, stat_busy,
         stat_err} !== 7'b0 || stat_bursts !== 32'd0) begin
      n_errors++;
      $display("FAIL midrst_outputs: aw/w/last/b/tready/busy/err=%b bursts=%0d required 0",
               {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready,
                stat_busy, stat_err}, stat_bursts);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n   = 1'b1;
    exp_idx = 0;
    exp_aw.delete();
    @(negedge clk);
    src_limit = src_acc;
    push_aw(1);
    run_bursts(1);
    n_checks++;
    if (stat_bursts !== 32'd1 || stat_err !== 1'b0 || exp_w.size() != 0) begin
      n_errors++;
      $display("FAIL midrst_recover: bursts=%0d err=%b w_left=%0d required 1 0 0",
               stat_bursts, stat_err, exp_w.size());
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    cfg_enable      = 1'b0;
    cfg_base_addr   = '0;
    cfg_ring_bursts = 16'd1;
    test_reset();
    test_single_burst();
    test_ring_wrap();
    test_random_stalls();
    test_bresp_error();
    test_enable_drop();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
